// File: rtl/cla32_sched_pkg.sv
// Shared definitions for the cla32 round-robin scheduler: data width, state encoding
// and the signed-overflow helper used when CLA32_SCHED_OVF_EN is defined.
package cla32_sched_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } sched_state_e;

    // b_eff is the operand as presented to the adder (already inverted for subtract)
    function automatic logic add_ovf(input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] b_eff,
                                     input logic [DATA_W-1:0] s);
        return (a[DATA_W-1] == b_eff[DATA_W-1]) && (s[DATA_W-1] != a[DATA_W-1]);
    endfunction

endpackage

// File: rtl/cla32.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups joined by group
// generate/propagate terms.
module cla32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] s_o,
    output logic        cout_o
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [7:0]  grp_g;
    logic [7:0]  grp_p;
    logic [8:0]  grp_c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        grp_g = '0;
        grp_p = '0;
        for (int j = 0; j < 8; j++) begin
            grp_g[j] = g[4*j+3]
                     | (p[4*j+3] & g[4*j+2])
                     | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            grp_p[j] = &p[4*j +: 4];
        end
    end

    // Scalar temporary keeps the group-carry chain free of self-referencing vectors
    always_comb begin
        logic carry;
        grp_c = '0;
        carry = cin_i;
        for (int j = 0; j < 8; j++) begin
            grp_c[j] = carry;
            carry    = grp_g[j] | (grp_p[j] & carry);
        end
        grp_c[8] = carry;
    end

    always_comb begin
        c = '0;
        for (int j = 0; j < 8; j++) begin
            c[4*j]   = grp_c[j];
            c[4*j+1] = g[4*j] | (p[4*j] & grp_c[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & grp_c[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & grp_c[j]);
        end
    end

    assign s_o    = p ^ c;
    assign cout_o = grp_c[8];

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after the pointer,
// wrapping modulo NREQ. Returns a one-hot grant and its encoded index.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] valid_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    int unsigned k;

    // Scan from the farthest offset down so the nearest valid requester wins
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        k       = 0;
        any_o   = |valid_i;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = (32'(ptr_i) + 32'(i)) % NREQ;
            if (valid_i[k]) begin
                grant_o    = '0;
                grant_o[k] = 1'b1;
                idx_o      = IDW'(k);
            end
        end
    end

endmodule

// File: rtl/cla32_rr_sched.sv
// Round-robin scheduler sharing one cla32 among NREQ requesters, with a one-deep
// registered response. Define CLA32_SCHED_OVF_EN to add the rsp_ovf_o signed-overflow output.
module cla32_rr_sched
    import cla32_sched_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NREQ-1:0]          req_valid_i,
    output logic [NREQ-1:0]          req_ready_o,
    input  logic [NREQ*DATA_W-1:0]   req_a_i,
    input  logic [NREQ*DATA_W-1:0]   req_b_i,
    input  logic [NREQ-1:0]          req_sub_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [IDW-1:0]           rsp_id_o,
    output logic [DATA_W-1:0]        rsp_s_o,
    output logic                     rsp_cout_o
`ifdef CLA32_SCHED_OVF_EN
    ,
    output logic                     rsp_ovf_o
`endif
);

    sched_state_e      state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    pick_idx;
    logic              any_valid;
    logic              slot_free;
    logic              accept;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] op_b_eff;
    logic              op_sub;
    logic [DATA_W-1:0] sum;
    logic              sum_cout;

    logic [DATA_W-1:0] s_q;
    logic              cout_q;
    logic [IDW-1:0]    id_q;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .grant_o (grant),
        .idx_o   (pick_idx),
        .any_o   (any_valid)
    );

    assign rsp_valid_o = (state_q == ST_FULL);
    assign slot_free   = (state_q == ST_IDLE) | (rsp_valid_o & rsp_ready_i);
    assign req_ready_o = slot_free ? grant : '0;
    assign accept      = slot_free & any_valid;

    always_comb begin
        op_a     = req_a_i[DATA_W*32'(pick_idx) +: DATA_W];
        op_b     = req_b_i[DATA_W*32'(pick_idx) +: DATA_W];
        op_sub   = req_sub_i[pick_idx];
        op_b_eff = op_sub ? ~op_b : op_b;
    end

    cla32 u_cla32 (
        .a_i    (op_a),
        .b_i    (op_b_eff),
        .cin_i  (op_sub),
        .s_o    (sum),
        .cout_o (sum_cout)
    );

    // An accept always refills the slot, so it takes priority over the drain
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (accept) begin
            state_d = ST_FULL;
            ptr_d   = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end else if (rsp_valid_o && rsp_ready_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (accept) begin
                s_q    <= sum;
                cout_q <= sum_cout;
                id_q   <= pick_idx;
            end
        end
    end

    assign rsp_s_o    = s_q;
    assign rsp_cout_o = cout_q;
    assign rsp_id_o   = id_q;

`ifdef CLA32_SCHED_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
        end else if (accept) begin
            ovf_q <= add_ovf(op_a, op_b_eff, sum);
        end
    end

    assign rsp_ovf_o = ovf_q;
`endif

endmodule

// File: tb/tb_cla32_rr_sched.sv
// Bench for cla32_rr_sched: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural scheduler model.
module tb_cla32_rr_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*32-1:0]   req_a;
    logic [NREQ*32-1:0]   req_b;
    logic [NREQ-1:0]      req_sub;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [31:0]          rsp_s;
    logic                 rsp_cout;
`ifdef CLA32_SCHED_OVF_EN
    logic                 rsp_ovf;
`endif

    always #5 clk = ~clk;

    cla32_rr_sched #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_sub_i   (req_sub),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_s_o     (rsp_s),
        .rsp_cout_o  (rsp_cout)
`ifdef CLA32_SCHED_OVF_EN
        ,
        .rsp_ovf_o   (rsp_ovf)
`endif
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: one held response plus a rotating priority pointer
    bit        m_full;
    int        m_ptr;
    int        m_id;
    bit [31:0] m_s;
    bit        m_cout;
    bit        m_ovf;
    int        grant_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full = 0;
        m_ptr  = 0;
        m_id   = 0;
        m_s    = '0;
        m_cout = 0;
        m_ovf  = 0;
    endtask

    // Compare the DUT against the model, then advance the model across the coming edge
    task automatic model_step();
        int              k;
        logic [31:0]     exp_ready;
        bit   [31:0]     a;
        bit   [31:0]     b;
        bit   [32:0]     total;
        if (!rst_n) begin
            model_reset();
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_rsp_s", rsp_s, 0);
            return;
        end
        k = -1;
        if (!m_full || rsp_ready) begin
            for (int i = 0; i < NREQ; i++) begin
                int j;
                j = (m_ptr + i) % NREQ;
                if (k < 0 && req_valid[j]) k = j;
            end
        end
        exp_ready = '0;
        if (k >= 0) exp_ready[k] = 1'b1;
        chk("req_ready", 32'(req_ready), exp_ready);
        chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_s", rsp_s, m_s);
        chk("rsp_cout", 32'(rsp_cout), 32'(m_cout));
`ifdef CLA32_SCHED_OVF_EN
        chk("rsp_ovf", 32'(rsp_ovf), 32'(m_ovf));
`endif
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) grant_log.push_back(i);
        if (k >= 0) begin
            a = req_a[32*k +: 32];
            b = req_b[32*k +: 32];
            if (req_sub[k]) b = ~b;
            total  = {1'b0, a} + {1'b0, b} + 33'(req_sub[k]);
            m_s    = total[31:0];
            m_cout = total[32];
            m_ovf  = (a[31] == b[31]) && (m_s[31] != a[31]);
            m_id   = k;
            m_full = 1;
            m_ptr  = (k + 1) % NREQ;
        end else if (m_full && rsp_ready) begin
            m_full = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b,
                           input logic sub);
        req_a[32*k +: 32] = a;
        req_b[32*k +: 32] = b;
        req_sub[k]        = sub;
        req_valid[k]      = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        rsp_ready = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("reset_valid", 32'(rsp_valid), 0);
        chk("reset_ready", 32'(req_ready), 0);

        // Single add wrapping to zero
        set_req(0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        #1 chk("add_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        #1;
        chk("add_valid", 32'(rsp_valid), 1);
        chk("add_s", rsp_s, 32'h0);
        chk("add_cout", 32'(rsp_cout), 1);
        chk("add_id", 32'(rsp_id), 0);

        // Subtract with borrow
        set_req(2, 32'd5, 32'd7, 1'b1);
        #1 chk("sub_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        #1;
        chk("sub_s", rsp_s, 32'hFFFF_FFFE);
        chk("sub_cout", 32'(rsp_cout), 0);
        chk("sub_id", 32'(rsp_id), 2);

        // Most-negative minus one: signed overflow
        set_req(3, 32'h8000_0000, 32'h1, 1'b1);
        #1 chk("ovf_ready", 32'(req_ready), 32'h8);
        tick();
        req_valid = '0;
        #1;
        chk("ovf_s", rsp_s, 32'h7FFF_FFFF);
        chk("ovf_cout", 32'(rsp_cout), 1);
        chk("ovf_id", 32'(rsp_id), 3);
`ifdef CLA32_SCHED_OVF_EN
        chk("ovf_flag", 32'(rsp_ovf), 1);
`endif

        // Fairness: all requesters valid, consumer always ready
        grant_log.delete();
        for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom, 1'($urandom));
        repeat (8) tick();
        chk("fair_count", 32'(grant_log.size()), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            chk("fair_order", 32'(grant_log[i]), 32'(i % NREQ));
        req_valid = '0;
        tick();

        // Backpressure: FULL held for three cycles, then immediate re-grant
        set_req(1, 32'd10, 32'd20, 1'b0);
        #1 chk("bp_first_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '1;
        rsp_ready = 1'b0;
        repeat (3) begin
            #1;
            chk("bp_ready", 32'(req_ready), 0);
            chk("bp_s", rsp_s, 32'd30);
            chk("bp_id", 32'(rsp_id), 1);
            tick();
        end
        rsp_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        tick();

        // Sparse and wrap: pointer at 3, only req1, then req3 and req0
        set_req(1, 32'd1, 32'd2, 1'b0);
        #1 chk("sparse_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        set_req(3, 32'd3, 32'd4, 1'b0);
        set_req(0, 32'd5, 32'd6, 1'b0);
        #1 chk("wrap_ready_3", 32'(req_ready), 32'h8);
        tick();
        #1 chk("wrap_ready_0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();

        // Randomized traffic with random backpressure and dropped requests
        repeat (400) begin
            req_valid = 4'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                req_a[32*i +: 32] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
                req_b[32*i +: 32] = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
                req_sub[i]        = 1'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Reset while a result is held
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        set_req(0, 32'h1234, 32'h1, 1'b0);
        tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        chk("pre_rst_valid", 32'(rsp_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 0);
        chk("mid_rst_s", rsp_s, 0);
        chk("mid_rst_id", 32'(rsp_id), 0);
        chk("mid_rst_cout", 32'(rsp_cout), 0);
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("post_rst_valid", 32'(rsp_valid), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
